sliding_window_buffer: RTL and testbench
========================================

Name: sliding_window_buffer

Overview:
- Raster-to-window front end directly upstream of pooling_layer; the same structure also serves the convolutional layer.
- Accepts one multi-channel pixel per enabled cycle in raster order.
- Keeps FILTER_SIZE-1 previous image rows in line buffers.
- Presents a complete FILTER_SIZE x FILTER_SIZE window with a valid strobe. It emits only windows fully inside the image, (IMAGE_WIDTH-FILTER_SIZE+1)*(IMAGE_HEIGHT-FILTER_SIZE+1) per frame.

Parameters:
D_WIDTH, 8, bits per channel sample
CHANNELS, 3, channels packed per pixel
FILTER_SIZE, 2, window edge length (>=2)
IMAGE_WIDTH, 64, pixels per row
IMAGE_HEIGHT, 32, rows per frame

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
clk_en  in  1  pixel-accept strobe; state advances only when high
input_data  in  CHANNELS*D_WIDTH  current pixel, channel 0 in MSBs
window_data  out  FILTER_SIZE*FILTER_SIZE*CHANNELS*D_WIDTH  registered window
valid  out  1  window_data holds a new complete window this cycle
frame_last  out  1  high with valid on the last window of a frame

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low on rst_n.
  - Asserting rst_n low immediately clears col and row counters to 0, valid to 0, frame_last to 0 and window_data to 0.
  - Line-buffer and window-register contents are not reset. Stale data is never exposed because of row/col gating.
- Accept: at a rising edge with clk_en=1, input_data is pixel (row,col).
  - The pixel is written into the window registers and line buffers.
  - col increments; at col=IMAGE_WIDTH-1, col wraps to 0 and row increments.
  - At row=IMAGE_HEIGHT-1, col=IMAGE_WIDTH-1, both wrap to 0: a new frame starts with no gap cycle.
- Output, latency 1: at the same edge, valid <= (row>=FILTER_SIZE-1) && (col>=FILTER_SIZE-1), using pre-increment counters.
  - window_data <= window whose bottom-right is the accepted pixel.
  - frame_last <= valid condition && row=IMAGE_HEIGHT-1 && col=IMAGE_WIDTH-1.
- Window layout: element (r,c), with r=0 the top (oldest) row and c=0 the leftmost column, has index k=r*FILTER_SIZE+c.
  - Element k occupies bits [P*(FILTER_SIZE*FILTER_SIZE-k)-1 -: P], where P=CHANNELS*D_WIDTH.
  - The top-left pixel is therefore in the MSBs.
- clk_en=0 at an edge: counters, buffers and window_data hold; valid and frame_last are 0 at that edge. A window is never repeated.
- Row boundary: windows at col<FILTER_SIZE-1 would straddle the previous row and are suppressed (valid=0).
- Frame boundary: rows 0..FILTER_SIZE-2 of a new frame produce no valid, so no window mixes two frames.
- Reset mid-frame: the next accepted pixel is treated as (0,0). The first valid is at pixel index (FILTER_SIZE-1)*IMAGE_WIDTH+FILTER_SIZE-1 after reset.
- Line buffers: FILTER_SIZE-1 delay lines of IMAGE_WIDTH pixels each, implemented as shift registers or RAM with a shared column pointer.
  - Write-before-read ordering must give the same window_data as an ideal raster window.
- No backpressure. The consumer takes every valid cycle.

Test Plan:
- Defaults; drive 2048 pixels, clk_en=1, channel values {i[7:0],i[7:0]+1,i[7:0]+2} for pixel i.
  - Exactly 1953 valid cycles.
  - First valid is the cycle after pixel 65 is accepted, with window pixels {p0,p1,p64,p65} MSB->LSB.
  - frame_last is high only on the 1953rd valid.
- Same stream with clk_en toggling 1,0,0,1 pseudo-randomly.
  - Identical ordered sequence of 1953 window_data values.
  - valid never high in the cycle after a clk_en=0 edge; window_data stable across gaps.
- Row edge: no valid after accepting pixels with col=0 for rows>=1 (e.g. pixel 128).
  - Window after pixel 129 = {p64,p65,p128,p129}.
- Two back-to-back frames.
  - Second frame first valid after pixel 2048+65, window {p2048,p2049,p2112,p2113}.
  - No valid for pixels 2048..2112; total 3906 valids.
- Reset mid-frame: pull rst_n low asynchronously (between edges) after pixel 1000.
  - valid, frame_last and window_data read 0 immediately.
  - After release, the first valid follows the 66th accepted pixel.
- FILTER_SIZE=3, IMAGE_WIDTH=8, IMAGE_HEIGHT=6.
  - 24 valids.
  - First window after pixel 18 = {p0,p1,p2,p8,p9,p10,p16,p17,p18}.

Source files
------------

// File: rtl/sliding_window_buffer_if.sv
// Pixel-in / window-out bundle for sliding_window_buffer.
//   clk_en      : pixel-accept strobe (producer -> buffer)
//   input_data  : one packed pixel, channel 0 in the MSBs
//   window_data : FILTER_SIZE x FILTER_SIZE window, top-left pixel in the MSBs
//   valid       : window_data holds a new complete window this cycle
//   frame_last  : high with valid on the last window of a frame
interface sliding_window_buffer_if #(
  parameter int unsigned D_WIDTH     = 8,
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned FILTER_SIZE = 2
);
  localparam int unsigned P  = CHANNELS * D_WIDTH;
  localparam int unsigned WW = FILTER_SIZE * FILTER_SIZE * P;

  logic          clk_en;
  logic [P-1:0]  input_data;
  logic [WW-1:0] window_data;
  logic          valid;
  logic          frame_last;

  modport master (
    output clk_en,
    output input_data,
    input  window_data,
    input  valid,
    input  frame_last
  );

  modport slave (
    input  clk_en,
    input  input_data,
    output window_data,
    output valid,
    output frame_last
  );
endinterface

// File: rtl/sliding_window_buffer.sv
// Raster-to-window front end: accepts one multi-channel pixel per enabled
// cycle in raster order, keeps FILTER_SIZE-1 previous rows in line buffers and
// emits every FILTER_SIZE x FILTER_SIZE window lying fully inside the image,
// one cycle after its bottom-right pixel is accepted.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (counters and outputs only)
//   bus   : slave side of sliding_window_buffer_if (clk_en, input_data in;
//           window_data, valid, frame_last out)
module sliding_window_buffer #(
  parameter int unsigned D_WIDTH      = 8,
  parameter int unsigned CHANNELS     = 3,
  parameter int unsigned FILTER_SIZE  = 2,
  parameter int unsigned IMAGE_WIDTH  = 64,
  parameter int unsigned IMAGE_HEIGHT = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sliding_window_buffer_if.slave  bus
);
  localparam int unsigned P    = CHANNELS * D_WIDTH;
  localparam int unsigned NWIN = FILTER_SIZE * FILTER_SIZE;
  localparam int unsigned CW   = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int unsigned RW   = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(FILTER_SIZE - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(FILTER_SIZE - 1);

  // lb_q[j] delays the stream by (j+1)*IMAGE_WIDTH pixels; tap [IMAGE_WIDTH-1]
  // is the same column j+1 rows above the pixel being accepted.
  logic [P-1:0]      lb_q  [FILTER_SIZE-1][IMAGE_WIDTH];
  logic [P-1:0]      win_q [FILTER_SIZE][FILTER_SIZE];
  logic [P-1:0]      win_d [FILTER_SIZE][FILTER_SIZE];
  logic [NWIN*P-1:0] window_d, window_q;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              col_wrap, row_wrap, in_window;

  always_comb begin
    win_d = win_q;
    // Shift every window row left by one column; the new right-hand column is
    // taken from the line-buffer taps (older rows) and the incoming pixel.
    for (int unsigned r = 0; r < FILTER_SIZE; r++) begin
      for (int unsigned c = 0; c < FILTER_SIZE - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
    end
    for (int unsigned r = 0; r < FILTER_SIZE - 1; r++) begin
      win_d[r][FILTER_SIZE-1] = lb_q[FILTER_SIZE-2-r][IMAGE_WIDTH-1];
    end
    win_d[FILTER_SIZE-1][FILTER_SIZE-1] = bus.input_data;

    window_d = '0;
    for (int unsigned r = 0; r < FILTER_SIZE; r++) begin
      for (int unsigned c = 0; c < FILTER_SIZE; c++) begin
        window_d[P*(NWIN-(r*FILTER_SIZE+c))-1 -: P] = win_d[r][c];
      end
    end

    col_wrap  = (col_q == COL_LAST);
    row_wrap  = (row_q == ROW_LAST);
    in_window = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
    col_d     = col_wrap ? '0 : col_q + CW'(1);
    row_d     = col_wrap ? (row_wrap ? '0 : row_q + RW'(1)) : row_q;
    valid_d   = bus.clk_en && in_window;
    last_d    = valid_d && col_wrap && row_wrap;
  end

  // Data path: not reset; row/col gating keeps stale contents out of any
  // window flagged valid.
  always_ff @(posedge clk) begin
    if (bus.clk_en) begin
      win_q       <= win_d;
      lb_q[0][0]  <= bus.input_data;
      for (int unsigned j = 1; j < FILTER_SIZE - 1; j++) begin
        lb_q[j][0] <= lb_q[j-1][IMAGE_WIDTH-1];
      end
      for (int unsigned j = 0; j < FILTER_SIZE - 1; j++) begin
        for (int unsigned i = 1; i < IMAGE_WIDTH; i++) begin
          lb_q[j][i] <= lb_q[j][i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q    <= '0;
      row_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      window_q <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      if (bus.clk_en) begin
        col_q    <= col_d;
        row_q    <= row_d;
        window_q <= window_d;
      end
    end
  end

  assign bus.window_data = window_q;
  assign bus.valid       = valid_q;
  assign bus.frame_last  = last_q;
endmodule

// File: tb/tb_sliding_window_buffer.sv
module tb_sliding_window_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sliding_window_buffer_if #(.D_WIDTH(8), .CHANNELS(3), .FILTER_SIZE(2)) ifa ();
  sliding_window_buffer_if #(.D_WIDTH(8), .CHANNELS(3), .FILTER_SIZE(3)) ifb ();

  sliding_window_buffer #(
    .D_WIDTH(8), .CHANNELS(3), .FILTER_SIZE(2), .IMAGE_WIDTH(64), .IMAGE_HEIGHT(32)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

  sliding_window_buffer #(
    .D_WIDTH(8), .CHANNELS(3), .FILTER_SIZE(3), .IMAGE_WIDTH(8), .IMAGE_HEIGHT(6)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  typedef struct {
    int   sel;
    int   pix;
    logic v;
    logic l;
    int   cnt;
    int   idx[9];
  } vec_t;

  vec_t tbl[$];

  int          checks = 0;
  int          errors = 0;
  logic [23:0] acc[$];
  int          first_valid_acc;
  logic        have_last;
  logic [215:0] last_exp;
  int          vcount, lcount;
  logic        o_valid, o_last;
  logic [215:0] o_win;

  task automatic chk(input string name, input logic [215:0] act, input logic [215:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pixv(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, b + 8'd1, b + 8'd2};
  endfunction

  task automatic add(input int sel, input int pix, input logic v, input logic l,
                     input int cnt, input int idx[9]);
    vec_t e;
    e.sel = sel; e.pix = pix; e.v = v; e.l = l; e.cnt = cnt; e.idx = idx;
    tbl.push_back(e);
  endtask

  task automatic model_reset();
    acc.delete();
    have_last = 1'b0;
    last_exp = '0;
    first_valid_acc = 0;
    vcount = 0;
    lcount = 0;
  endtask

  // One clock: drive, sample #1 after the edge, compare with the raster model.
  task automatic step(input int sel, input logic en, input int pix);
    int fs, w, h, n, pos, row, col, k;
    logic vexp, lexp;
    logic [215:0] ew;
    fs = (sel != 0) ? 3 : 2;
    w  = (sel != 0) ? 8 : 64;
    h  = (sel != 0) ? 6 : 32;
    if (sel == 0) begin
      ifa.clk_en = en; ifa.input_data = pixv(pix);
    end else begin
      ifb.clk_en = en; ifb.input_data = pixv(pix);
    end
    @(posedge clk);
    #1;
    if (sel == 0) begin
      o_valid = ifa.valid; o_last = ifa.frame_last; o_win = 216'(ifa.window_data);
      ifa.clk_en = 1'b0;
    end else begin
      o_valid = ifb.valid; o_last = ifb.frame_last; o_win = 216'(ifb.window_data);
      ifb.clk_en = 1'b0;
    end
    vexp = 1'b0; lexp = 1'b0; ew = '0;
    if (en) begin
      acc.push_back(pixv(pix));
      n   = acc.size() - 1;
      pos = n % (w * h);
      row = pos / w;
      col = pos % w;
      vexp = (row >= fs - 1) && (col >= fs - 1);
      lexp = vexp && (row == h - 1) && (col == w - 1);
      if (vexp) begin
        for (int r = 0; r < fs; r++) begin
          for (int c = 0; c < fs; c++) begin
            k = r * fs + c;
            ew[24*(fs*fs-k)-1 -: 24] = acc[n - (fs-1-r)*w - (fs-1-c)];
          end
        end
      end
    end
    chk("valid", 216'(o_valid), 216'(vexp));
    chk("frame_last", 216'(o_last), 216'(lexp));
    if (vexp) chk("window", o_win, ew);
    else if (!en && have_last) chk("window_hold", o_win, last_exp);
    if (en) begin
      have_last = vexp;
      if (vexp) last_exp = ew;
    end
    if (o_valid) begin
      vcount++;
      if (first_valid_acc == 0) first_valid_acc = acc.size();
    end
    if (o_last) lcount++;
  endtask

  task automatic run_table(input int sel, inout int next);
    logic [215:0] ew;
    int n;
    foreach (tbl[t]) begin
      if (tbl[t].sel != sel) continue;
      while (next <= tbl[t].pix) begin
        step(sel, 1'b1, next);
        next++;
      end
      chk("tbl_valid", 216'(o_valid), 216'(tbl[t].v));
      if (tbl[t].v) begin
        n = (sel != 0) ? 9 : 4;
        ew = '0;
        for (int k = 0; k < n; k++) ew[24*(n-k)-1 -: 24] = pixv(tbl[t].idx[k]);
        chk("tbl_window", o_win, ew);
        chk("tbl_last", 216'(o_last), 216'(tbl[t].l));
        chk("tbl_count", 216'(vcount), 216'(tbl[t].cnt));
      end
    end
  endtask

  task automatic async_reset_check();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 216'(ifa.valid), '0);
    chk("rst_frame_last", 216'(ifa.frame_last), '0);
    chk("rst_window", 216'(ifa.window_data), '0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int next, g;
    ifa.clk_en = 1'b0; ifa.input_data = '0;
    ifb.clk_en = 1'b0; ifb.input_data = '0;
    model_reset();

    add(0,   64, 1'b0, 1'b0,    0, '{0, 0, 0, 0, 0, 0, 0, 0, 0});
    add(0,   65, 1'b1, 1'b0,    1, '{0, 1, 64, 65, 0, 0, 0, 0, 0});
    add(0,  128, 1'b0, 1'b0,    0, '{0, 0, 0, 0, 0, 0, 0, 0, 0});
    add(0,  129, 1'b1, 1'b0,   64, '{64, 65, 128, 129, 0, 0, 0, 0, 0});
    add(0, 2047, 1'b1, 1'b1, 1953, '{1982, 1983, 2046, 2047, 0, 0, 0, 0, 0});
    add(0, 2048, 1'b0, 1'b0,    0, '{0, 0, 0, 0, 0, 0, 0, 0, 0});
    add(0, 2112, 1'b0, 1'b0,    0, '{0, 0, 0, 0, 0, 0, 0, 0, 0});
    add(0, 2113, 1'b1, 1'b0, 1954, '{2048, 2049, 2112, 2113, 0, 0, 0, 0, 0});
    add(1,   17, 1'b0, 1'b0,    0, '{0, 0, 0, 0, 0, 0, 0, 0, 0});
    add(1,   18, 1'b1, 1'b0,    1, '{0, 1, 2, 8, 9, 10, 16, 17, 18});
    add(1,   24, 1'b0, 1'b0,    0, '{0, 0, 0, 0, 0, 0, 0, 0, 0});
    add(1,   26, 1'b1, 1'b0,    7, '{8, 9, 10, 16, 17, 18, 24, 25, 26});
    add(1,   47, 1'b1, 1'b1,   24, '{29, 30, 31, 37, 38, 39, 45, 46, 47});

    // Power-on reset, checked while held.
    #1 rst_n = 1'b0;
    #2;
    chk("por_valid_a", 216'(ifa.valid), '0);
    chk("por_last_a", 216'(ifa.frame_last), '0);
    chk("por_window_a", 216'(ifa.window_data), '0);
    chk("por_valid_b", 216'(ifb.valid), '0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Two back-to-back frames, continuous enable.
    next = 0;
    run_table(0, next);
    while (next < 4096) begin
      step(0, 1'b1, next);
      next++;
    end
    chk("two_frame_valids", 216'(vcount), 216'(3906));
    chk("two_frame_lasts", 216'(lcount), 216'(2));
    chk("first_valid_accept", 216'(first_valid_acc), 216'(66));

    // Reset in the middle of a frame.
    for (int i = 0; i <= 1000; i++) step(0, 1'b1, i);
    chk("pre_reset_valid", 216'(ifa.valid), 216'(1));
    async_reset_check();

    // Same stream with randomly gapped enable, restarted from (0,0).
    for (int i = 0; i < 2048; i++) begin
      g = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 2)) : 0;
      for (int j = 0; j < g; j++) step(0, 1'b0, i + 7);
      step(0, 1'b1, i);
    end
    step(0, 1'b0, 0);
    chk("gapped_valids", 216'(vcount), 216'(1953));
    chk("gapped_lasts", 216'(lcount), 216'(1));
    chk("gapped_first_valid", 216'(first_valid_acc), 216'(66));

    // Small configuration: 3x3 window over 8x6 image.
    model_reset();
    next = 0;
    run_table(1, next);
    step(1, 1'b0, 0);
    chk("b_valids", 216'(vcount), 216'(24));
    chk("b_lasts", 216'(lcount), 216'(1));
    chk("b_first_valid", 216'(first_valid_acc), 216'(19));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
